// File: rtl/arb_types_pkg.sv
// rtl/arb_types_pkg.sv - shared types and constants for the RAM arbiter
package arb_types_pkg;
   localparam int WORD_W = 32;
   // Core index width; the arbiter supports one or two cores.
   localparam int CORE_W = 1;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic {
      IDLE  = 1'b0,
      SERVE = 1'b1
   } arbstate_t;

   typedef enum logic [1:0] {
      ICH = 2'd0,
      DRD = 2'd1,
      DWR = 2'd2
   } chan_t;

   typedef struct packed {
      logic [CORE_W-1:0] core;
      chan_t             chan;
   } grant_t;
endpackage

// File: rtl/arb_select.sv
// rtl/arb_select.sv - combinational request selector: first requesting core from rr_ptr, then dWEN > dREN > iREN
module arb_select
   import arb_types_pkg::*;
#(
   parameter int NCPU = 2
) (
   input  logic [NCPU-1:0]   iren,
   input  logic [NCPU-1:0]   dren,
   input  logic [NCPU-1:0]   dwen,
   input  logic [CORE_W-1:0] rr_ptr,
   output grant_t            grant,
   output logic              valid
);

   logic [CORE_W-1:0] c;

   always_comb begin
      valid = 1'b0;
      grant = '{core: '0, chan: ICH};
      c     = '0;
      for (int k = 0; k < NCPU; k++) begin
         c = CORE_W'((int'(rr_ptr) + k) % NCPU);
         if (!valid && (iren[c] || dren[c] || dwen[c])) begin
            valid      = 1'b1;
            grant.core = c;
            if (dwen[c])
               grant.chan = DWR;
            else if (dren[c])
               grant.chan = DRD;
            else
               grant.chan = ICH;
         end
      end
   end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - shares one RAM port among per-core I/D cache channels; ARB_ROUND_ROBIN_EN enables core rotation
module ram_arbiter
   import arb_types_pkg::*;
#(
   parameter int NCPU   = 2,
   parameter int WORD_W = arb_types_pkg::WORD_W
) (
   input  logic                   CLK,
   input  logic                   nRST,
   input  logic [NCPU-1:0]        iREN,
   input  logic [NCPU*WORD_W-1:0] iaddr,
   output logic [NCPU-1:0]        iwait,
   output logic [NCPU*WORD_W-1:0] iload,
   input  logic [NCPU-1:0]        dREN,
   input  logic [NCPU-1:0]        dWEN,
   input  logic [NCPU*WORD_W-1:0] daddr,
   input  logic [NCPU*WORD_W-1:0] dstore,
   output logic [NCPU-1:0]        dwait,
   output logic [NCPU*WORD_W-1:0] dload,
   output logic                   ramREN,
   output logic                   ramWEN,
   output logic [WORD_W-1:0]      ramaddr,
   output logic [WORD_W-1:0]      ramstore,
   input  logic [WORD_W-1:0]      ramload,
   input  logic [1:0]             ramstate
);

   arbstate_t         state_q, state_d;
   grant_t            grant_q, sel_grant;
   logic              sel_valid;
   logic [CORE_W-1:0] rr_ptr;
   logic              req_live, serving, complete;
   ramstate_t         rstate;

   logic [WORD_W-1:0] iaddr_a  [NCPU];
   logic [WORD_W-1:0] daddr_a  [NCPU];
   logic [WORD_W-1:0] dstore_a [NCPU];
   logic [WORD_W-1:0] iload_q  [NCPU];
   logic [WORD_W-1:0] dload_q  [NCPU];

   always_comb begin
      for (int c = 0; c < NCPU; c++) begin
         iaddr_a[c]  = iaddr[c*WORD_W +: WORD_W];
         daddr_a[c]  = daddr[c*WORD_W +: WORD_W];
         dstore_a[c] = dstore[c*WORD_W +: WORD_W];
      end
   end

   arb_select #(.NCPU(NCPU)) u_select (
      .iren   (iREN),
      .dren   (dREN),
      .dwen   (dWEN),
      .rr_ptr (rr_ptr),
      .grant  (sel_grant),
      .valid  (sel_valid)
   );

   // The grant stays tied to the live request line; dropping it aborts the transaction.
   always_comb begin
      case (grant_q.chan)
         DWR:     req_live = dWEN[grant_q.core];
         DRD:     req_live = dREN[grant_q.core];
         default: req_live = iREN[grant_q.core];
      endcase
   end

   assign rstate   = ramstate_t'(ramstate);
   assign serving  = (state_q == SERVE) && req_live;
   assign complete = serving && (rstate == ACCESS);

`ifdef ARB_ROUND_ROBIN_EN
   logic [CORE_W-1:0] rr_q;

   always_ff @(posedge CLK) begin
      if (!nRST)
         rr_q <= '0;
      else if (complete)
         rr_q <= CORE_W'((int'(grant_q.core) + 1) % NCPU);
   end

   assign rr_ptr = rr_q;
`else
   assign rr_ptr = '0;
`endif

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q <= IDLE;
         grant_q <= '{core: '0, chan: ICH};
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && sel_valid)
            grant_q <= sel_grant;
      end
   end

   // ERROR and abort both fall back to IDLE so the request is re-arbitrated.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (sel_valid) state_d = SERVE;
         SERVE:   if (!req_live || rstate == ACCESS || rstate == ERROR) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         for (int c = 0; c < NCPU; c++) begin
            iload_q[c] <= '0;
            dload_q[c] <= '0;
         end
      end else if (complete) begin
         if (grant_q.chan == ICH)
            iload_q[grant_q.core] <= ramload;
         else
            dload_q[grant_q.core] <= ramload;
      end
   end

   always_comb begin
      ramREN   = serving && (grant_q.chan != DWR);
      ramWEN   = serving && (grant_q.chan == DWR);
      ramaddr  = '0;
      ramstore = '0;
      if (state_q == SERVE) begin
         ramaddr = (grant_q.chan == ICH) ? iaddr_a[grant_q.core] : daddr_a[grant_q.core];
         if (grant_q.chan != ICH)
            ramstore = dstore_a[grant_q.core];
      end
      for (int c = 0; c < NCPU; c++) begin
         iwait[c] = !(complete && grant_q.core == CORE_W'(c) && grant_q.chan == ICH);
         dwait[c] = !(complete && grant_q.core == CORE_W'(c) && grant_q.chan != ICH);
         iload[c*WORD_W +: WORD_W] = !iwait[c] ? ramload : iload_q[c];
         dload[c*WORD_W +: WORD_W] = !dwait[c] ? ramload : dload_q[c];
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed self-checking bench for ram_arbiter (NCPU=2)
module tb_ram_arbiter;

   logic        CLK = 1'b0;
   logic        nRST;
   logic [1:0]  iREN, dREN, dWEN;
   logic [63:0] iaddr, daddr, dstore;
   logic [1:0]  iwait, dwait;
   logic [63:0] iload, dload;
   logic        ramREN, ramWEN;
   logic [31:0] ramaddr, ramstore, ramload;
   logic [1:0]  ramstate;

   int checks = 0;
   int fails  = 0;

   always #5 CLK = ~CLK;

   ram_arbiter #(.NCPU(2), .WORD_W(32)) dut (
      .CLK(CLK), .nRST(nRST),
      .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dwait(dwait), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_inputs();
      iREN = '0; dREN = '0; dWEN = '0;
      iaddr = '0; daddr = '0; dstore = '0;
      ramload = '0; ramstate = 2'd0;
   endtask

   int          exp_core;
   logic [31:0] exp_data;

   initial begin
      // Reset with every request asserted
      clear_inputs();
      nRST = 1'b0;
      iREN = 2'b11; dREN = 2'b11; dWEN = 2'b11;
      tick();
      tick();
      check("rst_iwait", 64'(iwait), 64'h3);
      check("rst_dwait", 64'(dwait), 64'h3);
      check("rst_ramREN", 64'(ramREN), 64'h0);
      check("rst_ramWEN", 64'(ramWEN), 64'h0);
      check("rst_ramaddr", 64'(ramaddr), 64'h0);
      check("rst_iload", iload, 64'h0);
      check("rst_dload", dload, 64'h0);
      nRST = 1'b1;
      #1;
      check("rst_release_ramWEN", 64'(ramWEN), 64'h0);
      tick();
      check("first_grant_write", 64'(ramWEN), 64'h1);
      check("first_grant_no_read", 64'(ramREN), 64'h0);
      clear_inputs();
      #1;
      check("first_abort_ramWEN", 64'(ramWEN), 64'h0);
      check("first_abort_dwait", 64'(dwait), 64'h3);
      tick();

      // Core0 instruction read, ACCESS on second SERVE cycle
      iREN[0] = 1'b1; iaddr[31:0] = 32'h40;
      #1;
      check("ird_idle_ramREN", 64'(ramREN), 64'h0);
      tick();
      ramstate = 2'd1;
      #1;
      check("ird_s1_ramREN", 64'(ramREN), 64'h1);
      check("ird_s1_ramaddr", 64'(ramaddr), 64'h40);
      check("ird_s1_iwait", 64'(iwait), 64'h3);
      tick();
      ramstate = 2'd2; ramload = 32'hDEADBEEF;
      #1;
      check("ird_done_iwait", 64'(iwait), 64'h2);
      check("ird_done_iload", 64'(iload[31:0]), 64'hDEADBEEF);
      tick();
      clear_inputs();
      #1;
      check("ird_after_iwait", 64'(iwait), 64'h3);
      check("ird_hold_iload", 64'(iload[31:0]), 64'hDEADBEEF);
      check("ird_after_ramREN", 64'(ramREN), 64'h0);

      // Core0 write and instruction read together: write first
      iREN[0] = 1'b1; iaddr[31:0] = 32'h40;
      dWEN[0] = 1'b1; daddr[31:0] = 32'h80; dstore[31:0] = 32'h1234;
      tick();
      check("wr_ramWEN", 64'(ramWEN), 64'h1);
      check("wr_ramREN", 64'(ramREN), 64'h0);
      check("wr_ramaddr", 64'(ramaddr), 64'h80);
      check("wr_ramstore", 64'(ramstore), 64'h1234);
      ramstate = 2'd2;
      #1;
      check("wr_done_dwait", 64'(dwait), 64'h2);
      check("wr_done_iwait", 64'(iwait), 64'h3);
      tick();
      dWEN[0] = 1'b0; ramstate = 2'd0;
      #1;
      check("bubble_ramWEN", 64'(ramWEN), 64'h0);
      check("bubble_ramREN", 64'(ramREN), 64'h0);
      tick();
      check("ird2_ramREN", 64'(ramREN), 64'h1);
      check("ird2_ramaddr", 64'(ramaddr), 64'h40);
      ramstate = 2'd2; ramload = 32'h55;
      #1;
      check("ird2_iwait", 64'(iwait), 64'h2);
      check("ird2_iload", 64'(iload[31:0]), 64'h55);
      tick();
      clear_inputs();

      // Both cores read data continuously
      dREN = 2'b11; daddr = {32'h200, 32'h100}; ramstate = 2'd2;
      for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
         exp_core = (i % 2 == 0) ? 1 : 0;
`else
         exp_core = 0;
`endif
         exp_data = 32'hA0 + 32'(i);
         ramload  = exp_data;
         tick();
         check("rr_ramaddr", 64'(ramaddr), (exp_core == 1) ? 64'h200 : 64'h100);
         check("rr_dwait", 64'(dwait), (exp_core == 1) ? 64'h1 : 64'h2);
         check("rr_dload", 64'(dload[exp_core*32 +: 32]), 64'(exp_data));
         tick();
      end
      clear_inputs();

      // ERROR then retry on core1
      dREN[1] = 1'b1; daddr[63:32] = 32'h200; ramstate = 2'd3;
      tick();
      check("err_ramREN", 64'(ramREN), 64'h1);
      check("err_dwait", 64'(dwait), 64'h3);
      tick();
      ramstate = 2'd0;
      #1;
      check("err_idle_dwait", 64'(dwait), 64'h3);
      check("err_idle_ramREN", 64'(ramREN), 64'h0);
      tick();
      check("retry_ramaddr", 64'(ramaddr), 64'h200);
      ramstate = 2'd2; ramload = 32'hCAFE;
      #1;
      check("retry_dwait", 64'(dwait), 64'h1);
      check("retry_dload", 64'(dload[63:32]), 64'hCAFE);
      tick();
      clear_inputs();

      // Abort: core1 drops dREN while served
      dREN[1] = 1'b1; daddr[63:32] = 32'h300;
      tick();
      check("abort_pre_ramREN", 64'(ramREN), 64'h1);
      dREN[1] = 1'b0;
      #1;
      check("abort_ramREN", 64'(ramREN), 64'h0);
      check("abort_dwait", 64'(dwait), 64'h3);
      tick();
      dREN[1] = 1'b1;
      #1;
      check("abort_idle_ramREN", 64'(ramREN), 64'h0);
      tick();
      check("abort_regrant_ramREN", 64'(ramREN), 64'h1);

      // Reset in the middle of a SERVE
      nRST = 1'b0;
      tick();
      check("midrst_ramREN", 64'(ramREN), 64'h0);
      check("midrst_dwait", 64'(dwait), 64'h3);
      check("midrst_dload", dload, 64'h0);
      check("midrst_iload", iload, 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
